// File: rtl/vec_prefetch_buf_if.sv
// Memory request/response bus of the vector prefetch buffer.
//   mem_req_val / mem_req_rdy   : request handshake
//   mem_req_transid             : 6-bit request tag
//   mem_req_addr                : line-aligned byte address
//   mem_resp_val                : response valid
//   mem_resp_transid            : tag of the returning line
//   mem_resp_data               : returned line
// master = prefetcher side, slave = memory side.
interface vec_prefetch_buf_if #(
    parameter int ADDR_W = 40,
    parameter int LINE_W = 512
);
    logic              mem_req_rdy;
    logic              mem_req_val;
    logic [5:0]        mem_req_transid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_val;
    logic [5:0]        mem_resp_transid;
    logic [LINE_W-1:0] mem_resp_data;

    modport master (
        output mem_req_val, mem_req_transid, mem_req_addr,
        input  mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
    );

    modport slave (
        input  mem_req_val, mem_req_transid, mem_req_addr,
        output mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
    );
endinterface

// File: rtl/vec_prefetch_buf.sv
// Vector prefetch buffer: loads a dense vector from memory line by line
// (tagged, out-of-order responses) into a local buffer and serves NUM_CH
// independent registered element reads.
//   clk, rst_n        : clock, async active-low reset
//   spmv_init         : abort/clear pulse
//   prefetch_start    : start pulse (IDLE only), with vec_ptr / vec_len
//   mem               : memory request/response bus (master side)
//   col_idx_in        : per-channel element index
//   col_val_out       : per-channel element value, one-cycle latency
//   prefetch_busy     : load in progress (REQ/WAIT/DRAIN)
//   prefetch_done     : vector fully loaded
//   len_err           : vec_len exceeded DEPTH, sticky until spmv_init
module vec_prefetch_buf #(
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 16,
    parameter int DEPTH     = 1024,
    parameter int LINE_W    = 512,
    parameter int MAX_OUTST = 16,
    parameter int ADDR_W    = 40,
    parameter int DIM_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spmv_init,
    input  logic                     prefetch_start,
    input  logic [ADDR_W-1:0]        vec_ptr,
    input  logic [DIM_W-1:0]         vec_len,
    vec_prefetch_buf_if.master       mem,
    input  logic [NUM_CH*DIM_W-1:0]  col_idx_in,
    output logic [NUM_CH*DATA_W-1:0] col_val_out,
    output logic                     prefetch_busy,
    output logic                     prefetch_done,
    output logic                     len_err
);
    localparam int VPL   = LINE_W / DATA_W;
    localparam int OFF_W = $clog2(VPL);
    localparam int LB    = $clog2(LINE_W / 8);
    localparam int EB    = LB - OFF_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int NL_W  = LEN_W + 1;
    localparam int PW    = NL_W + OFF_W;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [OFF_W-1:0]  off_q;
    logic [NL_W-1:0]   nl_q, issued_q, rcvd_q;
    logic [6:0]        outst_q;
    logic [63:0]       tag_vld_q;
    logic [NL_W-1:0]   tag_line_q [64];
    logic              len_err_q;
    logic [DATA_W-1:0] buffer [DEPTH];

    logic              len_over, start_go, hs, rsp_hit, rsp_wr, can_issue;
    logic [LEN_W-1:0]  start_len;
    logic [OFF_W-1:0]  start_off;
    logic [NL_W-1:0]   start_nl, rsp_line;
    logic [5:0]        req_tag;
    logic [PW-1:0]     wr_pos [VPL];
    logic              wr_en  [VPL];
    logic [AW-1:0]     wr_idx [VPL];
    logic              rd_ok  [NUM_CH];
    logic [AW-1:0]     rd_idx [NUM_CH];
    logic              unused_ptr_bits;

    assign unused_ptr_bits = ^vec_ptr[EB-1:0];

    // Start-time geometry: clamped length, element offset inside the first line, line count
    assign len_over  = 32'(vec_len) > 32'(DEPTH);
    assign start_len = len_over ? LEN_W'(DEPTH) : LEN_W'(vec_len);
    assign start_off = vec_ptr[LB-1:EB];
    assign start_nl  = NL_W'((NL_W'(start_off) + NL_W'(start_len) + NL_W'(VPL - 1)) >> OFF_W);
    assign start_go  = (state_q == S_IDLE) && prefetch_start && !spmv_init;

    assign req_tag  = issued_q[5:0];
    // A tag still in flight from 64 lines earlier blocks reuse until it returns
    assign can_issue = (state_q == S_REQ) && !spmv_init && (issued_q < nl_q) &&
                       (32'(outst_q) < 32'(MAX_OUTST)) && !tag_vld_q[req_tag];
    assign hs       = can_issue && mem.mem_req_rdy;
    assign rsp_hit  = mem.mem_resp_val && tag_vld_q[mem.mem_resp_transid];
    assign rsp_line = tag_line_q[mem.mem_resp_transid];
    assign rsp_wr   = rsp_hit && ((state_q == S_REQ) || (state_q == S_WAIT)) && !spmv_init;

    always_comb begin
        mem.mem_req_val     = can_issue;
        mem.mem_req_transid = req_tag;
        mem.mem_req_addr    = base_q + (ADDR_W'(issued_q) << LB);
        prefetch_busy       = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
        prefetch_done       = (state_q == S_DONE);
        len_err             = len_err_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = (start_len == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                if (spmv_init) state_d = S_DRAIN;
                else if (hs && (issued_q == nl_q - NL_W'(1))) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (spmv_init) state_d = S_DRAIN;
                else if (rcvd_q == nl_q) state_d = S_DONE;
            end
            S_DONE:  if (spmv_init) state_d = S_IDLE;
            // Leave as soon as the last outstanding line is being absorbed
            S_DRAIN: if ((outst_q == '0) || ((outst_q == 7'd1) && rsp_hit)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            off_q     <= '0;
            nl_q      <= '0;
            issued_q  <= '0;
            rcvd_q    <= '0;
            outst_q   <= '0;
            tag_vld_q <= '0;
            len_err_q <= 1'b0;
            for (int unsigned t = 0; t < 64; t++) tag_line_q[t] <= '0;
        end else begin
            state_q <= state_d;
            if (spmv_init) begin
                issued_q  <= '0;
                rcvd_q    <= '0;
                len_q     <= '0;
                len_err_q <= 1'b0;
            end else if (start_go) begin
                base_q    <= {vec_ptr[ADDR_W-1:LB], {LB{1'b0}}};
                len_q     <= start_len;
                off_q     <= start_off;
                nl_q      <= start_nl;
                issued_q  <= '0;
                rcvd_q    <= '0;
                len_err_q <= len_over;
            end else begin
                if (hs)     issued_q <= issued_q + NL_W'(1);
                if (rsp_wr) rcvd_q   <= rcvd_q + NL_W'(1);
            end
            case ({hs, rsp_hit})
                2'b10:   outst_q <= outst_q + 7'd1;
                2'b01:   outst_q <= outst_q - 7'd1;
                default: outst_q <= outst_q;
            endcase
            // hs and rsp_hit can never name the same tag (valid vs. not valid)
            if (rsp_hit) tag_vld_q[mem.mem_resp_transid] <= 1'b0;
            if (hs) begin
                tag_vld_q[req_tag]  <= 1'b1;
                tag_line_q[req_tag] <= issued_q;
            end
        end
    end

    // Word w of line k lands at element k*VPL + w - off when inside [0, len)
    always_comb begin
        for (int unsigned w = 0; w < VPL; w++) begin
            wr_pos[w] = (PW'(rsp_line) << OFF_W) + PW'(w);
            wr_en[w]  = rsp_wr && (wr_pos[w] >= PW'(off_q)) &&
                        (wr_pos[w] < (PW'(len_q) + PW'(off_q)));
            wr_idx[w] = AW'(wr_pos[w] - PW'(off_q));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < VPL; w++)
            if (wr_en[w]) buffer[wr_idx[w]] <= mem.mem_resp_data[w*DATA_W +: DATA_W];
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rd_ok[c]  = 32'(col_idx_in[c*DIM_W +: DIM_W]) < 32'(len_q);
            rd_idx[c] = AW'(col_idx_in[c*DIM_W +: DIM_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_val_out <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                col_val_out[c*DATA_W +: DATA_W] <= rd_ok[c] ? buffer[rd_idx[c]] : '0;
        end
    end
endmodule

// File: tb/tb_vec_prefetch_buf.sv
module tb_vec_prefetch_buf;
    localparam int DW = 32, NC = 16, DIMW = 16, AW = 40, LW = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic init1 = 0, start1 = 0, init2 = 0, start2 = 0;
    logic [AW-1:0] ptr1 = '0, ptr2 = '0;
    logic [DIMW-1:0] len1 = '0, len2 = '0;
    logic [NC*DIMW-1:0] idx1 = '0, idx2 = '0;
    logic [NC*DW-1:0] val1, val2;
    logic busy1, done1, err1, busy2, done2, err2;

    vec_prefetch_buf_if #(.ADDR_W(AW), .LINE_W(LW)) m1 ();
    vec_prefetch_buf_if #(.ADDR_W(AW), .LINE_W(LW)) m2 ();

    vec_prefetch_buf u_dut1 (
        .clk(clk), .rst_n(rst_n), .spmv_init(init1), .prefetch_start(start1),
        .vec_ptr(ptr1), .vec_len(len1), .mem(m1), .col_idx_in(idx1),
        .col_val_out(val1), .prefetch_busy(busy1), .prefetch_done(done1), .len_err(err1));

    vec_prefetch_buf #(.MAX_OUTST(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .spmv_init(init2), .prefetch_start(start2),
        .vec_ptr(ptr2), .vec_len(len2), .mem(m2), .col_idx_in(idx2),
        .col_val_out(val2), .prefetch_busy(busy2), .prefetch_done(done2), .len_err(err2));

    logic [45:0] rq1[$], rq2[$];
    always @(posedge clk) if (m1.mem_req_val && m1.mem_req_rdy) rq1.push_back({m1.mem_req_transid, m1.mem_req_addr});
    always @(posedge clk) if (m2.mem_req_val && m2.mem_req_rdy) rq2.push_back({m2.mem_req_transid, m2.mem_req_addr});

    int checks = 0, errors = 0;

    function automatic logic [31:0] wval(input logic [AW-1:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [LW-1:0] mkline(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        for (int w = 0; w < LW/DW; w++) l[w*DW +: DW] = wval(a + AW'(4*w));
        return l;
    endfunction

    function automatic logic [31:0] cv1(input int c); return val1[c*DW +: DW]; endfunction
    function automatic logic [31:0] cv2(input int c); return val2[c*DW +: DW]; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_req1(input string tag, input int i, input logic [5:0] tid, input logic [AW-1:0] a);
        logic [45:0] r;
        r = (i < rq1.size()) ? rq1[i] : '1;
        chk({tag, "_tid"}, 64'(r[45:40]), 64'(tid));
        chk({tag, "_addr"}, 64'(r[39:0]), 64'(a));
    endtask

    task automatic chk_req2(input string tag, input int i, input logic [5:0] tid, input logic [AW-1:0] a);
        logic [45:0] r;
        r = (i < rq2.size()) ? rq2[i] : '1;
        chk({tag, "_tid"}, 64'(r[45:40]), 64'(tid));
        chk({tag, "_addr"}, 64'(r[39:0]), 64'(a));
    endtask

    task automatic resp1(input logic [5:0] tid, input logic [AW-1:0] a);
        m1.mem_resp_val = 1'b1; m1.mem_resp_transid = tid; m1.mem_resp_data = mkline(a);
        tick();
        m1.mem_resp_val = 1'b0;
    endtask

    task automatic resp2(input logic [5:0] tid, input logic [AW-1:0] a);
        m2.mem_resp_val = 1'b1; m2.mem_resp_transid = tid; m2.mem_resp_data = mkline(a);
        tick();
        m2.mem_resp_val = 1'b0;
    endtask

    task automatic pulse_init1();
        init1 = 1'b1; tick(); init1 = 1'b0;
    endtask

    task automatic start_1(input logic [AW-1:0] p, input logic [DIMW-1:0] l);
        ptr1 = p; len1 = l; start1 = 1'b1; tick(); start1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, t;
        logic [45:0] r;
        m1.mem_req_rdy = 0; m1.mem_resp_val = 0; m1.mem_resp_transid = '0; m1.mem_resp_data = '0;
        m2.mem_req_rdy = 0; m2.mem_resp_val = 0; m2.mem_resp_transid = '0; m2.mem_resp_data = '0;
        #1 rst_n = 1'b0;
        tick();
        chk("rst_val", 64'(m1.mem_req_val), 0);
        chk("rst_addr", 64'(m1.mem_req_addr), 0);
        chk("rst_tid", 64'(m1.mem_req_transid), 0);
        chk("rst_busy", 64'(busy1), 0);
        chk("rst_done", 64'(done1), 0);
        chk("rst_lenerr", 64'(err1), 0);
        chk("rst_colval_nz", 64'(|val1), 0);
        rst_n = 1'b1;
        tick(2);
        m1.mem_req_rdy = 1'b1;

        // Aligned 2-line vector, in-order responses
        b = rq1.size();
        start_1(40'h1000, 16'd32);
        chk("t24_busy", 64'(busy1), 1);
        chk("t24_val", 64'(m1.mem_req_val), 1);
        tick(3);
        chk("t24_nreq", 64'(rq1.size() - b), 2);
        chk_req1("t24_req0", b, 6'd0, 40'h1000);
        chk_req1("t24_req1", b + 1, 6'd1, 40'h1040);
        chk("t24_val_wait", 64'(m1.mem_req_val), 0);
        resp1(6'd0, 40'h1000);
        tick();
        chk("t24_notdone", 64'(done1), 0);
        resp1(6'd1, 40'h1040);
        tick();
        chk("t24_done", 64'(done1), 1);
        chk("t24_busy_done", 64'(busy1), 0);
        idx1[0*DIMW +: DIMW] = 16'd31; idx1[1*DIMW +: DIMW] = 16'd0;
        idx1[2*DIMW +: DIMW] = 16'd32; idx1[3*DIMW +: DIMW] = 16'd16;
        tick();
        chk("t24_rd31", 64'(cv1(0)), 64'(wval(40'h107C)));
        chk("t24_rd0", 64'(cv1(1)), 64'(wval(40'h1000)));
        chk("t24_rd32", 64'(cv1(2)), 0);
        chk("t24_rd16", 64'(cv1(3)), 64'(wval(40'h1040)));
        chk("t24_done_hold", 64'(done1), 1);
        pulse_init1();
        chk("t24_init_done", 64'(done1), 0);
        chk("t24_init_busy", 64'(busy1), 0);

        // Unaligned start, out-of-order responses
        b = rq1.size();
        start_1(40'h1008, 16'd16);
        tick(3);
        chk("t25_nreq", 64'(rq1.size() - b), 2);
        chk_req1("t25_req0", b, 6'd0, 40'h1000);
        chk_req1("t25_req1", b + 1, 6'd1, 40'h1040);
        resp1(6'd1, 40'h1040);
        resp1(6'd0, 40'h1000);
        tick();
        chk("t25_done", 64'(done1), 1);
        idx1[0*DIMW +: DIMW] = 16'd0; idx1[1*DIMW +: DIMW] = 16'd15; idx1[2*DIMW +: DIMW] = 16'd16;
        tick();
        chk("t25_rd0", 64'(cv1(0)), 64'(wval(40'h1008)));
        chk("t25_rd15", 64'(cv1(1)), 64'(wval(40'h1044)));
        chk("t25_rd16", 64'(cv1(2)), 0);
        pulse_init1();

        // Zero length
        b = rq1.size();
        start_1(40'h1000, 16'd0);
        chk("t28_zero_done", 64'(done1), 1);
        chk("t28_zero_busy", 64'(busy1), 0);
        tick(2);
        chk("t28_zero_noreq", 64'(rq1.size() - b), 0);
        pulse_init1();

        // Over-length vector clamped to DEPTH
        b = rq1.size();
        start_1(40'h2000, 16'd2000);
        chk("t28_lenerr", 64'(err1), 1);
        for (int i = 0; i < 64; i++) begin
            t = 0;
            while (rq1.size() <= b + i && t < 100) begin tick(); t++; end
            chk("t28_wait_req", 64'(rq1.size() > b + i), 1);
            if (rq1.size() <= b + i) break;
            r = rq1[b + i];
            chk("t28_tid", 64'(r[45:40]), 64'(i));
            chk("t28_addr", 64'(r[39:0]), 64'(40'h2000 + 40'(64 * i)));
            resp1(r[45:40], r[39:0]);
        end
        tick();
        chk("t28_done", 64'(done1), 1);
        chk("t28_nreq", 64'(rq1.size() - b), 64);
        chk("t28_lenerr_hold", 64'(err1), 1);
        idx1[0*DIMW +: DIMW] = 16'd1023; idx1[1*DIMW +: DIMW] = 16'd1024; idx1[2*DIMW +: DIMW] = 16'd3;
        tick();
        chk("t28_rd1023", 64'(cv1(0)), 64'(wval(40'h2FFC)));
        chk("t28_rd1024", 64'(cv1(1)), 0);
        chk("t28_rd3", 64'(cv1(2)), 64'(wval(40'h200C)));
        pulse_init1();
        chk("t28_lenerr_clr", 64'(err1), 0);

        // Abort during WAIT with 3 lines outstanding
        b = rq1.size();
        start_1(40'h3000, 16'd48);
        tick(4);
        chk("t27_nreq", 64'(rq1.size() - b), 3);
        pulse_init1();
        chk("t27_drain_busy", 64'(busy1), 1);
        chk("t27_drain_val", 64'(m1.mem_req_val), 0);
        tick(3);
        chk("t27_drain_noreq", 64'(rq1.size() - b), 3);
        resp1(6'd2, 40'h3080);
        chk("t27_busy_a", 64'(busy1), 1);
        resp1(6'd0, 40'h3000);
        chk("t27_busy_b", 64'(busy1), 1);
        resp1(6'd1, 40'h3040);
        chk("t27_idle", 64'(busy1), 0);
        chk("t27_notdone", 64'(done1), 0);
        b = rq1.size();
        start_1(40'h4000, 16'd32);
        tick(3);
        chk("t27_new_nreq", 64'(rq1.size() - b), 2);
        resp1(6'd1, 40'h4040);
        idx1[0*DIMW +: DIMW] = 16'd3; idx1[1*DIMW +: DIMW] = 16'd20;
        tick();
        chk("t27_stale3", 64'(cv1(0)), 64'(wval(40'h200C)));
        chk("t27_rd20", 64'(cv1(1)), 64'(wval(40'h4050)));
        resp1(6'd0, 40'h4000);
        tick();
        chk("t27_new_done", 64'(done1), 1);
        chk("t27_rd3", 64'(cv1(0)), 64'(wval(40'h400C)));
        pulse_init1();

        // Outstanding limit of 2 on the second instance
        m2.mem_req_rdy = 1'b1;
        ptr2 = 40'h6000; len2 = 16'd64; start2 = 1'b1; tick(); start2 = 1'b0;
        tick(6);
        chk("t26_nreq2", 64'(rq2.size()), 2);
        chk("t26_val_stall", 64'(m2.mem_req_val), 0);
        resp2(6'd1, 40'h6040);
        tick(2);
        chk("t26_nreq3", 64'(rq2.size()), 3);
        chk("t26_val_stall2", 64'(m2.mem_req_val), 0);
        resp2(6'd0, 40'h6000);
        tick(2);
        chk("t26_nreq4", 64'(rq2.size()), 4);
        chk_req2("t26_req2", 2, 6'd2, 40'h6080);
        chk_req2("t26_req3", 3, 6'd3, 40'h60C0);
        resp2(6'd3, 40'h60C0);
        resp2(6'd2, 40'h6080);
        tick();
        chk("t26_done", 64'(done2), 1);
        idx2[0*DIMW +: DIMW] = 16'd0;  idx2[1*DIMW +: DIMW] = 16'd17;
        idx2[2*DIMW +: DIMW] = 16'd40; idx2[3*DIMW +: DIMW] = 16'd63;
        idx2[4*DIMW +: DIMW] = 16'd64;
        tick();
        chk("t26_rd0", 64'(cv2(0)), 64'(wval(40'h6000)));
        chk("t26_rd17", 64'(cv2(1)), 64'(wval(40'h6044)));
        chk("t26_rd40", 64'(cv2(2)), 64'(wval(40'h60A0)));
        chk("t26_rd63", 64'(cv2(3)), 64'(wval(40'h60FC)));
        chk("t26_rd64", 64'(cv2(4)), 0);

        // Asynchronous reset while a request is stalled
        m1.mem_req_rdy = 1'b0;
        start_1(40'h5000, 16'd32);
        chk("t29_val", 64'(m1.mem_req_val), 1);
        chk("t29_addr", 64'(m1.mem_req_addr), 64'h5000);
        tick();
        chk("t29_addr_hold", 64'(m1.mem_req_addr), 64'h5000);
        chk("t29_val_hold", 64'(m1.mem_req_val), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t29_val_rst", 64'(m1.mem_req_val), 0);
        chk("t29_busy_rst", 64'(busy1), 0);
        chk("t29_addr_rst", 64'(m1.mem_req_addr), 0);
        chk("t29_done2_rst", 64'(done2), 0);
        tick();
        rst_n = 1'b1;
        tick(2);
        chk("t29_idle_after", 64'(busy1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_prefetch_buf.md
VEC_PREFETCH_BUF -- requirements
Module: vec_prefetch_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, vector element width in bits.
REQ-002 SHALL have parameter NUM_CH, default 16, number of independent read channels.
REQ-003 SHALL have parameter DEPTH, default 1024, maximum vector length in elements (power of 2).
REQ-004 SHALL have parameter LINE_W, default 512, memory response line width in bits; VPL = LINE_W/DATA_W elements per line (power of 2).
REQ-005 SHALL have parameter MAX_OUTST, default 16, maximum in-flight line requests (1..64).
REQ-006 SHALL have parameters ADDR_W, default 40, and DIM_W, default 16.
REQ-007 SHALL have ports, clock and reset first:
 clk  in  1  sole clock
 rst_n  in  1  reset, asynchronous, active-low
 spmv_init  in  1  abort/clear pulse
 prefetch_start  in  1  start pulse, sampled only in IDLE
 vec_ptr  in  ADDR_W  byte address of element 0
 vec_len  in  DIM_W  element count
 mem_req_rdy  in  1  memory accepts request
 mem_req_val  out  1  request valid
 mem_req_transid  out  6  request tag
 mem_req_addr  out  ADDR_W  line-aligned request address
 mem_resp_val  in  1  response valid
 mem_resp_transid  in  6  response tag
 mem_resp_data  in  LINE_W  line data, element w at bits [w*DATA_W +: DATA_W]
 col_idx_in  in  NUM_CH*DIM_W  per-channel element index, channel c at [c*DIM_W +: DIM_W]
 col_val_out  out  NUM_CH*DATA_W  per-channel element value
 prefetch_busy  out  1  FSM not IDLE/DONE
 prefetch_done  out  1  vector fully loaded
 len_err  out  1  vec_len exceeded DEPTH (sticky until init)

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, DONE, DRAIN.
REQ-009 IDLE on prefetch_start SHALL latch vec_ptr, len = min(vec_len, DEPTH), off = element offset of vec_ptr within its line, NL = ceil((off+len)/VPL), then go to REQ; if len=0, go directly to DONE.
REQ-010 SHALL set len_err in the start cycle when vec_len > DEPTH.
REQ-011 REQ SHALL assert mem_req_val while issued < NL and outstanding < MAX_OUTST; line k address = (vec_ptr with low log2(LINE_W/8) bits cleared) + k*LINE_W/8, transid = k mod 64.
REQ-012 Request SHALL be accepted only on mem_req_val && mem_req_rdy; addr/transid SHALL hold stable while val is high and rdy is low.
REQ-013 REQ SHALL go to WAIT on the handshake of line NL-1.
REQ-014 SHALL record line index per transid in a 64-entry table with a valid bit per entry; responses MAY return in any order.
REQ-015 A response with a valid tag SHALL write element e = k*VPL + w - off for each w where 0 <= e < len, then clear the tag valid bit, in one cycle.
REQ-016 A response with an invalid tag SHALL be dropped with no state change.
REQ-017 Same-cycle request handshake and response SHALL keep the outstanding count unchanged.
REQ-018 WAIT SHALL go to DONE when received = NL; DONE SHALL assert prefetch_done and hold until spmv_init.
REQ-019 spmv_init SHALL clear done, len_err and counters; from REQ/WAIT it SHALL go to DRAIN, deassert mem_req_val, drop all response data, and go to IDLE when outstanding = 0; from IDLE/DONE it SHALL go to IDLE.
REQ-020 prefetch_start outside IDLE SHALL be ignored.
REQ-021 col_val_out[c] SHALL be registered, one-cycle latency: value of buffer[col_idx_in[c]] if col_idx_in[c] < len, else 0; all NUM_CH reads are independent and concurrent.
REQ-022 Buffer contents SHALL NOT be cleared by spmv_init; only len gating (REQ-021) hides stale data.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, mem_req_val=0, mem_req_transid=0, mem_req_addr=0, col_val_out=0, prefetch_busy=0, prefetch_done=0, len_err=0, counters and tag table cleared; buffer contents undefined.

Verification
REQ-024 vec_ptr=0x1000, vec_len=32, VPL=16, rdy=1, in-order responses -> 2 requests (0x1000,0x1040, tags 0,1), done after 2nd response, col_idx 31 reads mem word 15 of line 1.
REQ-025 vec_ptr=0x1008 (off=2), vec_len=16 -> NL=2; element 0 = line0 word2, element 15 = line1 word1; col_idx 16 -> 0.
REQ-026 vec_len=64, MAX_OUTST=2, responses withheld -> exactly 2 handshakes then mem_req_val=0; returning tags 1 then 0 resumes issue; all 4 lines written correctly.
REQ-027 spmv_init in WAIT with 3 outstanding -> DRAIN, no requests, 3 late responses dropped, IDLE next cycle after the last; new start succeeds.
REQ-028 vec_len=0 -> DONE next cycle, no requests; vec_len=2000 -> len_err=1, len=1024, 64 lines requested.
REQ-029 rst_n asserted mid-REQ with rdy low -> mem_req_val and prefetch_busy drop immediately without a clock edge.
